// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs - generic elastic pipeline stage register (F/D, D/X, X/M, M/W).
//
// Carries a data bundle and a control bundle across a valid/ready boundary.
// A main register drives the outputs; a skid register catches one extra beat
// while downstream is stalled, so the stage runs at 1 beat/cycle with a
// registered in_ready.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   upstream holds a valid beat
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream data bundle   [DATA_W]
//   in_ctrl    upstream control bundle [CTRL_W]
//   out_valid  stage presents a valid beat
//   out_ready  downstream consumes the beat this cycle
//   out_data   registered data bundle (never masked)
//   out_ctrl   registered control bundle, 0 whenever out_valid=0
//   flush      squash every held beat
//   stall_cnt  [CNT_W] cycles with out_valid & !out_ready (PERF build only)
//   flush_cnt  [CNT_W] flushes that squashed a held beat  (PERF build only)
//
// Build option: define PIPE_STAGE_HS_PERF_EN to add the two saturating
// performance counters. Handshake behaviour is identical in both builds.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no beat held, out_valid=0, in_ready=1
// ONE   | beat in main register, skid empty, in_ready=1
// FULL  | main and skid both hold beats, in_ready=0
module pipe_stage_hs #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush
`ifdef PIPE_STAGE_HS_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : gBadParam
        $error("pipe_stage_hs: DATA_W, CTRL_W and CNT_W must all be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic              skidValid;
    logic              outValidQ;
    logic              inReadyQ;

    logic accept;
    logic consume;

    // inReadyQ mirrors !skidValid as a register; gating with rst keeps the
    // stage closed while reset is held yet open on the first cycle after it.
    assign in_ready = inReadyQ & ~rst;
    assign accept   = in_valid & in_ready;
    assign consume  = outValidQ & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            mainData  <= '0;
            mainCtrl  <= '0;
            skidData  <= '0;
            skidCtrl  <= '0;
            skidValid <= 1'b0;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
        end else if (flush) begin
            // out_data keeps its last value; out_ctrl is zeroed by the mask.
            state     <= EMPTY;
            skidValid <= 1'b0;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainData  <= in_data;
                        mainCtrl  <= in_ctrl;
                        outValidQ <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        mainData <= in_data;
                        mainCtrl <= in_ctrl;
                    end else if (accept) begin
                        skidData  <= in_data;
                        skidCtrl  <= in_ctrl;
                        skidValid <= 1'b1;
                        inReadyQ  <= 1'b0;
                        state     <= FULL;
                    end else if (consume) begin
                        outValidQ <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        mainData  <= skidData;
                        mainCtrl  <= skidCtrl;
                        skidData  <= '0;
                        skidCtrl  <= '0;
                        skidValid <= 1'b0;
                        inReadyQ  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    skidValid <= 1'b0;
                    outValidQ <= 1'b0;
                    inReadyQ  <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid = outValidQ;
    assign out_data  = mainData;
    assign out_ctrl  = mainCtrl & {CTRL_W{outValidQ}};

`ifdef PIPE_STAGE_HS_PERF_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (outValidQ && !out_ready && !(&stallCnt)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (flush && (outValidQ || skidValid) && !(&flushCnt)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs - self-checking bench for pipe_stage_hs.
// Beats are pushed to a scoreboard queue on accept and popped/compared on
// consume; each scenario task also checks its own cycle-exact expectations.
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [63:0] inData;
    logic [15:0] inCtrl;
    logic        outValid;
    logic        outReady;
    logic [63:0] outData;
    logic [15:0] outCtrl;
    logic        flush;

    int          checks = 0;
    int          errors = 0;
    int          consumeCnt;
    logic [79:0] sbQ[$];
    logic [79:0] expBeat;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_HS_PERF_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic [1:0]  stallCnt2;
    logic [1:0]  flushCnt2;
    logic        inReady2;
    logic        outValid2;
    logic [63:0] outData2;
    logic [15:0] outCtrl2;
`endif

    pipe_stage_hs #(.DATA_W(64), .CTRL_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_ctrl   (inCtrl),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_ctrl  (outCtrl),
        .flush     (flush)
`ifdef PIPE_STAGE_HS_PERF_EN
        ,
        .stall_cnt (stallCnt),
        .flush_cnt (flushCnt)
`endif
    );

`ifdef PIPE_STAGE_HS_PERF_EN
    pipe_stage_hs #(.DATA_W(64), .CTRL_W(16), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady2),
        .in_data   (inData),
        .in_ctrl   (inCtrl),
        .out_valid (outValid2),
        .out_ready (outReady),
        .out_data  (outData2),
        .out_ctrl  (outCtrl2),
        .flush     (flush),
        .stall_cnt (stallCnt2),
        .flush_cnt (flushCnt2)
    );
`endif

    task automatic drive(input logic v, input logic [63:0] d, input logic [15:0] c,
                         input logic r, input logic f);
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        outReady = r;
        flush    = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 64'hDEAD_BEEF, 16'hFFFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", outValid); end
        checks++;
        if (outCtrl !== 16'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0000", outCtrl); end
        checks++;
        if (inReady !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", inReady); end
        checks++;
        if (outData !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", outData); end
        rst = 1'b0;
        drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", inReady); end
        @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", outValid); end
        sbQ.delete();
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 10; c++) begin
            drive(c < 8, 64'(c), 16'(c + 1), 1'b1, 1'b0);
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (inReady !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, inReady); end
            end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (outValid !== 1'b1 || outData !== 64'(c - 1)) begin
                    errors++;
                    $display("FAIL stream_latency c=%0d: got v=%b d=%h want v=1 d=%h", c, outValid, outData, 64'(c - 1));
                end
            end
            if (outValid && outReady) begin
                checks++;
                if (sbQ.size() == 0) begin errors++; $display("FAIL stream_order: got unexpected beat %h want none", outData); end
                else begin
                    expBeat = sbQ.pop_front();
                    if ({outCtrl, outData} !== expBeat) begin errors++; $display("FAIL stream_order: got %h want %h", {outCtrl, outData}, expBeat); end
                end
            end
            if (flush) sbQ.delete();
            else if (inValid && inReady) sbQ.push_back({inCtrl, inData});
            @(posedge clk);
            #1;
        end
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d pending want 0", sbQ.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  expRdy = 8'b1110_0011;
        logic [63:0] d;
        consumeCnt = 0;
        for (int c = 0; c < 8; c++) begin
            d = (c == 0) ? 64'h11 : (c == 1) ? 64'h22 : 64'h33;
            drive(c <= 5, d, d[15:0], c >= 4, 1'b0);
            @(negedge clk);
            checks++;
            if (inReady !== expRdy[c]) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, inReady, expRdy[c]); end
            if (c == 2 || c == 3) begin
                checks++;
                if (outValid !== 1'b1 || outData !== 64'h11 || outCtrl !== 16'h11) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d: got v=%b d=%h c=%h want v=1 d=11 c=0011", c, outValid, outData, outCtrl);
                end
            end
            if (c == 7) begin
                checks++;
                if (outValid !== 1'b0 || outCtrl !== 16'h0) begin
                    errors++;
                    $display("FAIL bp_bubble: got v=%b c=%h want v=0 c=0000", outValid, outCtrl);
                end
            end
            if (outValid && outReady) begin
                consumeCnt++;
                checks++;
                if (sbQ.size() == 0) begin errors++; $display("FAIL bp_order: got unexpected beat %h want none", outData); end
                else begin
                    expBeat = sbQ.pop_front();
                    if ({outCtrl, outData} !== expBeat) begin errors++; $display("FAIL bp_order: got %h want %h", {outCtrl, outData}, expBeat); end
                end
            end
            if (flush) sbQ.delete();
            else if (inValid && inReady) sbQ.push_back({inCtrl, inData});
            @(posedge clk);
            #1;
        end
        checks++;
        if (consumeCnt != 3 || sbQ.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got consumed=%0d pending=%0d want 3 and 0", consumeCnt, sbQ.size());
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        for (int c = 0; c < 8; c++) begin
            d = (c == 0) ? 64'h11 : (c == 1) ? 64'h22 : 64'h44;
            drive(c <= 2 || c == 6, d, d[15:0], c >= 3, c == 2 || c == 6);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (outValid !== 1'b0 || outCtrl !== 16'h0 || inReady !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_full: got v=%b c=%h rdy=%b want v=0 c=0000 rdy=1", outValid, outCtrl, inReady);
                end
                checks++;
                if (outData !== 64'h11) begin errors++; $display("FAIL flush_data_hold: got %h want 11", outData); end
            end
            if (c == 4 || c == 5 || c == 7) begin
                checks++;
                if (outValid !== 1'b0) begin errors++; $display("FAIL flush_no_emerge c=%0d: got v=%b d=%h want v=0", c, outValid, outData); end
            end
            if (outValid && outReady) begin
                checks++;
                if (sbQ.size() == 0) begin errors++; $display("FAIL flush_order: got unexpected beat %h want none", outData); end
                else begin
                    expBeat = sbQ.pop_front();
                    if ({outCtrl, outData} !== expBeat) begin errors++; $display("FAIL flush_order: got %h want %h", {outCtrl, outData}, expBeat); end
                end
            end
            if (flush) sbQ.delete();
            else if (inValid && inReady) sbQ.push_back({inCtrl, inData});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_accept_consume();
        logic [63:0] d;
        for (int c = 0; c < 4; c++) begin
            d = (c == 0) ? 64'h55 : 64'h66;
            drive(c <= 1, d, d[15:0], 1'b1, 1'b0);
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (outValid !== 1'b1 || outData !== 64'h55) begin errors++; $display("FAIL ac_first: got v=%b d=%h want v=1 d=55", outValid, outData); end
            end
            if (c == 2) begin
                checks++;
                if (outValid !== 1'b1 || outData !== 64'h66 || outCtrl !== 16'h66 || inReady !== 1'b1) begin
                    errors++;
                    $display("FAIL ac_replace: got v=%b d=%h c=%h rdy=%b want v=1 d=66 c=0066 rdy=1", outValid, outData, outCtrl, inReady);
                end
            end
            if (c == 3) begin
                checks++;
                if (outValid !== 1'b0) begin errors++; $display("FAIL ac_drain: got v=%b want 0", outValid); end
            end
            if (outValid && outReady) begin
                checks++;
                if (sbQ.size() == 0) begin errors++; $display("FAIL ac_order: got unexpected beat %h want none", outData); end
                else begin
                    expBeat = sbQ.pop_front();
                    if ({outCtrl, outData} !== expBeat) begin errors++; $display("FAIL ac_order: got %h want %h", {outCtrl, outData}, expBeat); end
                end
            end
            if (flush) sbQ.delete();
            else if (inValid && inReady) sbQ.push_back({inCtrl, inData});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'hA1, 16'hA1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 64'hB2, 16'hB2, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 64'h77, 16'h77, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (inReady !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", inReady); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (outValid !== 1'b0 || outCtrl !== 16'h0 || outData !== 64'h0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b c=%h d=%h rdy=%b want v=0 c=0000 d=0 rdy=1", outValid, outCtrl, outData, inReady);
        end
        sbQ.delete();
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (outValid !== 1'b0) begin errors++; $display("FAIL rstmid_skid_dropped: got v=%b d=%h want v=0", outValid, outData); end
        end
    endtask

`ifdef PIPE_STAGE_HS_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 64'h99, 16'h99, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stallCnt !== 16'd5) begin errors++; $display("FAIL perf_stall: got %0d want 5", stallCnt); end
        checks++;
        if (stallCnt2 !== 2'd3) begin errors++; $display("FAIL perf_stall_sat: got %0d want 3", stallCnt2); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (flushCnt !== 16'd1 || stallCnt !== 16'd6 || stallCnt2 !== 2'd3) begin
            errors++;
            $display("FAIL perf_flush: got flush=%0d stall=%0d stall2=%0d want 1 6 3", flushCnt, stallCnt, stallCnt2);
        end
        sbQ.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "simulation timed out");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_accept_consume();
        test_reset_mid();
`ifdef PIPE_STAGE_HS_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
